pipe_mem_arbiter: RTL and testbench
===================================

# pipe_mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction fetch (stage 1) and data access (stage 4). Requests are sequenced through a small FSM with a request/acknowledge handshake to variable-latency memory. A wait-cycle watchdog bounds each access. A single pipeline-wide stall freezes every pipeline register until all accesses for the current step have completed.

## Interface
- `TIMEOUT`, default 255: wait cycles allowed in a busy state before an access is aborted (1..255).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `inst_addr` in 32: fetch address from the PC.
- `if_req` in 1: a fetch is required this step.
- `instr` out 32: fetched instruction, registered.
- `data_addr` in 32: data address (EX/MEM ALU result).
- `data_in` in 32: store data.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `data_out` out 32: load result, registered.
- `pipe_stall` out 1: freezes PC and all pipeline registers while high.
- `bus_err` out 1: sticky; an access timed out.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out 32: memory address, registered.
- `mem_wdata` out 32: memory write data, registered.
- `mem_rdata` in 32: memory read data; valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: access complete; sampled at the rising edge.

## Operation
- `dm_req` = `mem_read | mem_write`. If both are high, the access is a write and `data_out` is left unchanged.
- Internal flags `if_done` and `dm_done` mark the accesses already completed in the current step.
- `pipe_stall` = `(if_req & ~if_done) | (dm_req & ~dm_done)`. This is combinational.
- At an edge where `pipe_stall` is 0, both flags clear and the pipeline advances.
- FSM states: IDLE, DM_BUSY, IF_BUSY.
- **IDLE:**
  - If `dm_req & ~dm_done`, go to DM_BUSY.
  - Else if `if_req & ~if_done`, go to IF_BUSY.
  - Else stay in IDLE.
  - On entry to a busy state, register `mem_req`=1, `mem_addr`, `mem_we` and `mem_wdata` (`data_in`); clear the wait counter.
- Priority: data always wins over fetch, because the data access belongs to the older instruction.
- **Busy state, `mem_ack` seen at an edge:**
  - Set the matching done flag.
  - In DM_BUSY, latch `mem_rdata` into `data_out` on reads only.
  - In IF_BUSY, latch `mem_rdata` into `instr`.
  - Next state: if DM_BUSY completes and a fetch is still pending, go directly to IF_BUSY (`mem_req` stays high; `mem_addr`=`inst_addr`, `mem_we`=0). Otherwise go to IDLE with `mem_req`=0.
- **Busy state, no ack:**
  - Hold all `mem_*` outputs stable; increment the wait counter (8 bits).
  - When the counter equals `TIMEOUT` with no ack: abort the access, set `bus_err`, and complete as if acked with read data 32'h0000_0000 (a NOP on fetch).
- `bus_err` clears only on reset.
- Addresses and write data are captured at issue; later input changes do not affect an access in flight.
- **Reset (asserted at any time, including mid-access):**
  - Immediately: state IDLE, flags 0, counter 0, `mem_req` 0, `mem_we` 0.
  - `mem_addr`, `mem_wdata`, `instr` and `data_out` go to 0.
  - `bus_err` goes to 0.
  - An abandoned memory transaction is not resumed.
- While in reset, `pipe_stall` = `if_req | dm_req`.

## Timing
- Minimum cost per access is 2 cycles: 1 issue cycle plus 1 busy cycle with `mem_ack` high.
- Fetch-only step with zero-wait memory:
  - Cycle 0: IDLE.
  - Cycle 1: `mem_req` high, ack.
  - Cycle 2: `pipe_stall` low, `instr` valid.
  - The pipeline advances at the end of cycle 2.
- Load plus fetch, zero-wait:
  - Cycle 0: issue.
  - Cycle 1: DM ack.
  - Cycle 2: IF ack.
  - Cycle 3: `pipe_stall` low.
- An ack arriving after N wait cycles delays the step by exactly N cycles.
- `mem_ack` while `mem_req` is low is ignored.
- Timeout abort occurs TIMEOUT+1 cycles after issue.
- `instr` and `data_out` hold their values until the next completing access of the same kind.

## Test plan
- **Reset mid-access:** reset low during DM_BUSY with `mem_req`=1 -> `mem_req`=0, `instr`=0, `data_out`=0, `bus_err`=0 asynchronously. After release with `if_req`=1, a fetch is issued 1 cycle later.
- **Fetch only:** `if_req`=1, `inst_addr`=0x0000_0040, memory acks in the first busy cycle with 0x2008_0005 -> `mem_addr`=0x40, `mem_we`=0, `instr`=0x2008_0005, `pipe_stall` high for 2 cycles then low for 1.
- **Load and fetch together:** `data_addr`=0x100, `mem_read`=1, `inst_addr`=0x44, acks return 0xDEAD_BEEF then 0x0000_0020 -> data access issued first, then fetch back-to-back, `data_out`=0xDEAD_BEEF, `instr`=0x20, stall for 3 cycles.
- **Store with wait states:** `mem_write`=1, `data_in`=0x1234_5678, `data_addr`=0x200, ack after 3 wait cycles -> `mem_we`=1, `mem_wdata`=0x1234_5678 stable across all waits, `data_out` unchanged.
- **Timeout:** `TIMEOUT`=4, fetch with no ack -> abort 5 cycles after issue, `instr`=0, `bus_err`=1 and held across later good accesses.
- **Read and write together:** `mem_read`=`mem_write`=1 -> a single write access, `data_out` unchanged, one ack completes the step.

Source files
------------

// File: rtl/pipe_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : pipe_mem_arbiter_if
// Purpose   : Request/acknowledge bus between the pipeline memory arbiter and
//             a variable-latency, single-ported unified memory.
// Signals   : mem_req   - access request, held until acknowledged or aborted
//             mem_we    - 1 = write, 0 = read (valid while mem_req is high)
//             mem_addr  - access address
//             mem_wdata - write data
//             mem_rdata - read data, valid in the cycle mem_ack is high
//             mem_ack   - access complete, sampled on the rising clock edge
// Modports  : master (arbiter side), slave (memory side)
// Revision  : 1.0 - initial release
// ============================================================================
interface pipe_mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            data access. Data access is served first, then fetch; a single
//            pipeline stall is held until every access of the step is done.
//            A wait-cycle watchdog aborts an access that is never acked.
// Ports    : clk, reset (async, active-low)
//            inst_addr, if_req, instr           - fetch side
//            data_addr, data_in, mem_read,
//            mem_write, data_out                - data side
//            pipe_stall                         - freezes the pipeline
//            bus_err                            - sticky timeout flag
//            mem                                - memory bus (master)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        inst_addr,
  input  logic               if_req,
  output logic [31:0]        instr,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_in,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic [31:0]        data_out,
  output logic               pipe_stall,
  output logic               bus_err,
  pipe_mem_arbiter_if.master mem
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        if_done, if_done_nx;
  logic        dm_done, dm_done_nx;
  logic [7:0]  wait_cnt, wait_cnt_nx;
  logic        req_q, req_nx;
  logic        we_q, we_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [31:0] instr_nx, data_out_nx;
  logic        bus_err_nx;

  logic        dm_req, dm_pend, if_pend;
  logic        timed_out, finish;
  logic [31:0] rdata_eff;

  assign dm_req     = mem_read | mem_write;
  assign dm_pend    = dm_req & ~dm_done;
  assign if_pend    = if_req & ~if_done;
  assign pipe_stall = if_pend | dm_pend;

  // An ack in the same cycle the counter reaches the limit still wins.
  assign timed_out  = ~mem.mem_ack & (wait_cnt == TIMEOUT_CNT);
  assign finish     = mem.mem_ack | timed_out;
  // Aborted accesses complete with all-zero data (a NOP on fetch).
  assign rdata_eff  = mem.mem_ack ? mem.mem_rdata : 32'h0000_0000;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      wait_cnt <= 8'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      instr    <= 32'h0;
      data_out <= 32'h0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      if_done  <= if_done_nx;
      dm_done  <= dm_done_nx;
      wait_cnt <= wait_cnt_nx;
      req_q    <= req_nx;
      we_q     <= we_nx;
      addr_q   <= addr_nx;
      wdata_q  <= wdata_nx;
      instr    <= instr_nx;
      data_out <= data_out_nx;
      bus_err  <= bus_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    if_done_nx  = if_done;
    dm_done_nx  = dm_done;
    wait_cnt_nx = wait_cnt;
    req_nx      = req_q;
    we_nx       = we_q;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    instr_nx    = instr;
    data_out_nx = data_out;
    bus_err_nx  = bus_err;

    case (state)
      IDLE: begin
        // Data first: it belongs to the older instruction.
        if (dm_pend) begin
          state_nx    = DM_BUSY;
          req_nx      = 1'b1;
          we_nx       = mem_write;
          addr_nx     = data_addr;
          wdata_nx    = data_in;
          wait_cnt_nx = 8'd0;
        end else if (if_pend) begin
          state_nx    = IF_BUSY;
          req_nx      = 1'b1;
          we_nx       = 1'b0;
          addr_nx     = inst_addr;
          wdata_nx    = data_in;
          wait_cnt_nx = 8'd0;
        end
      end

      DM_BUSY: begin
        if (finish) begin
          dm_done_nx  = 1'b1;
          bus_err_nx  = bus_err | timed_out;
          wait_cnt_nx = 8'd0;
          // The captured direction decides; read+write is a write.
          if (!we_q) begin
            data_out_nx = rdata_eff;
          end
          if (if_pend) begin
            // Chain straight into the fetch without an idle cycle.
            state_nx = IF_BUSY;
            we_nx    = 1'b0;
            addr_nx  = inst_addr;
          end else begin
            state_nx = IDLE;
            req_nx   = 1'b0;
          end
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end

      IF_BUSY: begin
        if (finish) begin
          if_done_nx  = 1'b1;
          bus_err_nx  = bus_err | timed_out;
          wait_cnt_nx = 8'd0;
          instr_nx    = rdata_eff;
          state_nx    = IDLE;
          req_nx      = 1'b0;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase

    // The step is over: the pipeline advances and the done flags rearm.
    if (!pipe_stall) begin
      if_done_nx = 1'b0;
      dm_done_nx = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mem_arbiter
// Purpose  : Self-checking bench for pipe_mem_arbiter. A memory responder
//            acks each request after a chosen number of wait cycles; a
//            step-level reference model predicts stall length, access order,
//            returned values and the sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_arbiter;
  localparam int TO = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        if_req = 1'b0;
  logic [31:0] instr;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_out;
  logic        pipe_stall;
  logic        bus_err;

  pipe_mem_arbiter_if bus ();

  pipe_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_addr (inst_addr),
    .if_req    (if_req),
    .instr     (instr),
    .data_addr (data_addr),
    .data_in   (data_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_out  (data_out),
    .pipe_stall(pipe_stall),
    .bus_err   (bus_err),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_checks = 0;
  int          step_no = 0;
  int          stable_err = 0;
  int          wait_q[$];
  acc_t        acc_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_instr = 32'h0;
  logic [31:0] ref_dout = 32'h0;
  logic        ref_berr = 1'b0;

  function logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem_arr[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: ack after the queued number of wait cycles, log every
  // request and flag any change of the bus while a request is outstanding.
  initial begin
    logic in_req;
    int   cyc;
    int   cur_wait;
    acc_t cur;
    in_req = 1'b0;
    cyc = 0;
    cur_wait = 0;
    cur = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'hBAD0_BAD0;
      if (bus.mem_req !== 1'b1) begin
        in_req = 1'b0;
      end else begin
        if (!in_req) begin
          in_req = 1'b1;
          cyc = 0;
          cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          cur = acc_t'({bus.mem_we, bus.mem_addr, bus.mem_wdata});
          acc_q.push_back(cur);
        end else if (cur !== acc_t'({bus.mem_we, bus.mem_addr, bus.mem_wdata})) begin
          stable_err++;
        end
        if (cyc == cur_wait) begin
          bus.mem_ack = 1'b1;
          if (cur.we) mem_arr[cur.addr] = cur.wdata;
          else bus.mem_rdata = mem_rd(cur.addr);
          in_req = 1'b0;
        end else begin
          cyc++;
        end
      end
    end
  end

  // One pipeline step: predict, drive, wait for the stall to drop, compare.
  task automatic do_step(input logic ifr, input logic rd, input logic wr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] di, input int w_dm, input int w_if);
    int    exp_cnt;
    int    cnt;
    int    ew;
    logic  ab;
    acc_t  exp_acc[$];
    string s;
    step_no++;
    s = $sformatf("step%0d", step_no);
    exp_cnt = 0;
    if (rd | wr) begin
      ab = (w_dm > TO);
      ew = ab ? TO : w_dm;
      exp_cnt += 1 + ew;
      exp_acc.push_back(acc_t'({wr, da, di}));
      if (ab) begin
        ref_berr = 1'b1;
        if (!wr) ref_dout = 32'h0;
      end else if (wr) begin
        ref_mem[da] = di;
      end else begin
        ref_dout = ref_rd(da);
      end
    end
    if (ifr) begin
      ab = (w_if > TO);
      ew = ab ? TO : w_if;
      exp_cnt += 1 + ew;
      exp_acc.push_back(acc_t'({1'b0, ia, 32'h0}));
      if (ab) ref_berr = 1'b1;
      ref_instr = ab ? 32'h0 : ref_rd(ia);
    end
    if (exp_cnt > 0) exp_cnt++;

    @(negedge clk);
    if_req = ifr;
    mem_read = rd;
    mem_write = wr;
    inst_addr = ia;
    data_addr = da;
    data_in = di;
    acc_q.delete();
    stable_err = 0;
    if (rd | wr) wait_q.push_back(w_dm);
    if (ifr) wait_q.push_back(w_if);
    #1;
    cnt = 0;
    while (pipe_stall === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
      #1;
    end

    check({s, "_stall_cycles"}, 32'(cnt), 32'(exp_cnt));
    check({s, "_instr"}, instr, ref_instr);
    check({s, "_data_out"}, data_out, ref_dout);
    check({s, "_bus_err"}, 32'(bus_err), 32'(ref_berr));
    check({s, "_mem_req_idle"}, 32'(bus.mem_req), 32'd0);
    check({s, "_n_access"}, 32'(acc_q.size()), 32'(exp_acc.size()));
    check({s, "_bus_stable"}, 32'(stable_err), 32'd0);
    for (int i = 0; i < exp_acc.size(); i++) begin
      if (i < acc_q.size()) begin
        check($sformatf("%s_acc%0d_we", s, i), 32'(acc_q[i].we), 32'(exp_acc[i].we));
        check($sformatf("%s_acc%0d_addr", s, i), acc_q[i].addr, exp_acc[i].addr);
        if (exp_acc[i].we) begin
          check($sformatf("%s_acc%0d_wdata", s, i), acc_q[i].wdata, exp_acc[i].wdata);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rst_val;
    // Reset state, sampled after the first edge has applied the reset.
    mem_read = 1'b1;
    #7;
    check("rst_stall_dm", 32'(pipe_stall), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    mem_read = 1'b0;
    #1;
    check("rst_stall_none", 32'(pipe_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fetch only, zero wait.
    preload(32'h40, 32'h2008_0005);
    do_step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 0);
    // Load then fetch, back to back.
    preload(32'h100, 32'hDEAD_BEEF);
    preload(32'h44, 32'h0000_0020);
    do_step(1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 0, 0);
    // Store with three wait cycles.
    do_step(1'b0, 1'b0, 1'b1, 32'h48, 32'h200, 32'h1234_5678, 3, 0);
    // Read and write together: one write access.
    do_step(1'b0, 1'b1, 1'b1, 32'h48, 32'h204, 32'hCAFE_0001, 1, 0);
    // Load back the stored word, with waits on both accesses.
    do_step(1'b1, 1'b1, 1'b0, 32'h48, 32'h200, 32'h0, 2, 1);
    // Fetch that is never acked: aborted, zero instruction, bus_err.
    do_step(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 0, 1000);
    // Good fetch afterwards: bus_err stays set.
    do_step(1'b1, 1'b0, 1'b0, 32'h84, 32'h0, 32'h0, 0, 2);

    // Reset in the middle of a data access.
    @(negedge clk);
    if_req = 1'b0;
    mem_read = 1'b1;
    mem_write = 1'b0;
    data_addr = 32'h500;
    wait_q.delete();
    wait_q.push_back(3);
    @(negedge clk);
    #1;
    check("rstmid_req_before", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rstmid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rstmid_mem_addr", bus.mem_addr, 32'h0);
    check("rstmid_instr", instr, 32'h0);
    check("rstmid_data_out", data_out, 32'h0);
    check("rstmid_bus_err", 32'(bus_err), 32'd0);
    check("rstmid_stall", 32'(pipe_stall), 32'd1);
    ref_instr = 32'h0;
    ref_dout = 32'h0;
    ref_berr = 1'b0;
    rst_val = 32'h0BAD_F00D;
    preload(32'h600, rst_val);
    @(negedge clk);
    mem_read = 1'b0;
    if_req = 1'b1;
    inst_addr = 32'h600;
    wait_q.delete();
    wait_q.push_back(0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rstrel_fetch_req", 32'(bus.mem_req), 32'd1);
    check("rstrel_fetch_addr", bus.mem_addr, 32'h600);
    check("rstrel_fetch_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    #1;
    check("rstrel_stall", 32'(pipe_stall), 32'd0);
    check("rstrel_instr", instr, rst_val);
    ref_instr = rst_val;

    // Randomized steps over a small address pool so loads hit earlier stores.
    for (int k = 0; k < 40; k++) begin
      do_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'h300 + 32'(4 * $urandom_range(0, 7)),
              32'h300 + 32'(4 * $urandom_range(0, 7)),
              32'($urandom()),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
